rgb_grayscaler: RTL and testbench
=================================

Name: rgb_grayscaler

Overview:
- Consumer end of the RGB pixel buffer's read interface. Takes the R,G,B byte stream (rwm_data/rwm_valid) and applies back-pressure through pause.
- Converts each R,G,B triple into one 8-bit luma byte and emits it downstream with a valid/ready handshake, e.g. to the grayscale frame store.
- Pulses gs_done once N*M gray pixels have been accepted downstream.

Parameters:
- N, 2, image height in pixels
- M, 2, image width in pixels
- WR, 77, red weight (8-bit unsigned)
- WG, 150, green weight (8-bit unsigned)
- WB, 29, blue weight (8-bit unsigned); WR+WG+WB must equal 256

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- gs_enable  in  1  controller enable; low means idle and discard input
- rwm_data  in  8  byte from the pixel buffer, order R,G,B per pixel
- rwm_valid  in  1  rwm_data holds a byte this cycle
- pause  out  1  combinational back-pressure to the pixel buffer
- gray_data  out  8  luma byte
- gray_valid  out  1  gray_data valid; held until accepted
- gray_ready  in  1  downstream accepts when gray_valid & gray_ready
- gs_done  out  1  one-cycle pulse on acceptance of the frame's last pixel

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, collector count=0, s1_v=0, gray_valid=0, gray_data=0, gs_done=0, pixel count=0. A mid-frame reset drops all partial data.
- Byte acceptance rule: every cycle with rwm_valid=1 in ACTIVE is captured, including cycles where pause=1. The buffer still advances its address on those cycles, so no byte may be dropped.
- Collector: holds R and G plus an overflow slot; cnt ranges 0..3. Bytes are stored in arrival order.
- Stage-1 register (s1): holds the product sum WR*R + WG*G + WB*B as 16 bits. The maximum value is 65280, so it never overflows.
- Output register: gray_data = s1_sum[15:8] (truncate, no rounding).
- Free signals:
  - s2_free = ~gray_valid | gray_ready
  - s1_free = ~s1_v | s2_free
- Triple transfer to s1:
  - cnt==2 & rwm_valid & s1_free: transfer (R,G,rwm_data); cnt becomes 0.
  - cnt==2 & rwm_valid & ~s1_free: store the byte; cnt becomes 3.
  - cnt==3 & s1_free: transfer the stored triple; cnt becomes 0.
  - cnt==3 & rwm_valid in the same cycle is unreachable by construction. If it occurs anyway, the transfer still happens and the new byte becomes R with cnt=1.
- pause = gs_enable & (cnt>=2) & ~s1_free.
  - Guarantees at most one byte arrives after pause first asserts, and that byte fits in the overflow slot.
- s1 advances to the output register when s1_v & s2_free.
- gray_valid stays high and gray_data stays stable until gray_ready.
- Latency: B byte presented in cycle t with the pipeline free gives gray_valid=1 from cycle t+2. Sustained throughput is 1 pixel per 3 cycles.
- FSM:
  - IDLE: pause=0; rwm_valid ignored. Goes to ACTIVE when gs_enable=1.
  - ACTIVE: normal operation as above. On acceptance of pixel N*M: pixel count resets to 0, gs_done=1 in the following cycle, go to DONE.
  - DONE: one cycle, then ACTIVE if gs_enable=1, else IDLE.
- gs_enable dropping during ACTIVE: go to IDLE immediately and clear the collector, s1, gray_valid and pixel count. The controller must not deassert gs_enable mid-frame; this is defined recovery only.
- gray_valid stays low in IDLE and DONE. Any pending output is always drained before gs_done.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, ACTIVE, DONE
  - default luma weights
  - FRAME_PIXELS = N*M as a localparam helper
- One natural sub-module: luma_mac, the combinational WR*R+WG*G+WB*B 16-bit adder tree, instantiated in front of s1.

Test Plan:
- gray_ready=1; bytes 100,50,200 on three consecutive cycles -> gray_data=82 with gray_valid high two cycles after the B byte; pause never asserted.
- Triples (255,255,255), (0,0,0), (255,0,0), (0,255,0) with N=M=2 -> outputs 255, 0, 76, 149; gs_done pulses once, exactly one cycle after the 4th acceptance.
- gray_ready=0 while streaming 12 bytes -> pause rises at cnt==2 once the pipeline is full; exactly one further byte is captured (cnt=3); releasing gray_ready yields all 4 correct outputs in order with no loss or duplication.
- Apply rst_n=0 for one cycle after the G byte of pixel 2 -> all outputs 0 next cycle; a fresh 12-byte frame then produces exactly 4 outputs and one gs_done.
- gs_enable=0 with rwm_valid=1 for 6 bytes -> no gray_valid, pause=0; then enable and send (0,0,255) -> gray_data=28.

Source files
------------

// File: rtl/rgb_grayscaler_pkg.sv
// Shared definitions for the RGB-to-luma converter: FSM encoding, default
// image geometry and luma weights.
package rgb_grayscaler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_N  = 2;
    localparam int DEF_M  = 2;
    // BT.601-style weights scaled so that they sum to 256
    localparam int DEF_WR = 77;
    localparam int DEF_WG = 150;
    localparam int DEF_WB = 29;

    localparam int FRAME_PIXELS = DEF_N * DEF_M;

    function automatic int frame_pixels(input int n, input int m);
        return n * m;
    endfunction

endpackage

// File: rtl/rgb_grayscaler_if.sv
// Byte stream from the pixel buffer plus the gray pixel handshake to the
// downstream frame store.
interface rgb_grayscaler_if;

    logic [7:0] rwm_data;
    logic       rwm_valid;
    logic       pause;
    logic [7:0] gray_data;
    logic       gray_valid;
    logic       gray_ready;

    modport master (
        output rwm_data, rwm_valid, gray_ready,
        input  pause, gray_data, gray_valid
    );

    modport slave (
        input  rwm_data, rwm_valid, gray_ready,
        output pause, gray_data, gray_valid
    );

endinterface

// File: rtl/rgb_grayscaler_luma_mac.sv
// Combinational weighted sum WR*R + WG*G + WB*B; with weights summing to 256
// the result never exceeds 65280 and fits in 16 bits.
module luma_mac
    import rgb_grayscaler_pkg::*;
#(
    parameter int WR = DEF_WR,
    parameter int WG = DEF_WG,
    parameter int WB = DEF_WB
) (
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [15:0] sum
);

    localparam logic [15:0] WR16 = 16'(WR);
    localparam logic [15:0] WG16 = 16'(WG);
    localparam logic [15:0] WB16 = 16'(WB);

    assign sum = (WR16 * {8'd0, r}) + (WG16 * {8'd0, g}) + (WB16 * {8'd0, b});

endmodule

// File: rtl/rgb_grayscaler.sv
// Collects R,G,B bytes, converts each triple to an 8-bit luma value through a
// two-stage pipeline, and pulses gs_done once a full frame has been accepted.
module rgb_grayscaler
    import rgb_grayscaler_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int M  = DEF_M,
    parameter int WR = DEF_WR,
    parameter int WG = DEF_WG,
    parameter int WB = DEF_WB
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gs_enable,
    rgb_grayscaler_if.slave bus,
    output logic            gs_done
);

    localparam int FRAME = frame_pixels(N, M);
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME - 1);

    state_t        state;
    logic [1:0]    cnt;
    logic [7:0]    r_byte, g_byte, b_byte;
    logic          s1_v;
    logic [15:0]   s1_sum;
    logic [7:0]    gray_data;
    logic          gray_valid;
    logic [CW-1:0] pix_cnt;

    logic          accept, last_accept, s2_free, adv_ok, s1_free, s1_adv, load_s1;
    logic [7:0]    mac_b;
    logic [15:0]   mac_sum;
    logic          unused_frac;

    // The last pixel of a frame must leave alone: s1 is held back for that
    // cycle and through DONE so gray_valid stays low until the next frame.
    assign accept      = (state == ACTIVE) & gray_valid & bus.gray_ready;
    assign last_accept = accept & (pix_cnt == LAST_PIX);
    assign s2_free     = ~gray_valid | bus.gray_ready;
    assign adv_ok      = (state == ACTIVE) & ~last_accept;
    assign s1_free     = ~s1_v | (s2_free & adv_ok);
    assign s1_adv      = s1_v & s2_free & adv_ok;
    assign load_s1     = (state != IDLE) & s1_free &
                         (((cnt == 2'd2) & bus.rwm_valid) | (cnt == 2'd3));
    assign mac_b       = (cnt == 2'd3) ? b_byte : bus.rwm_data;

    assign bus.pause      = gs_enable & cnt[1] & ~s1_free;
    assign bus.gray_data  = gray_data;
    assign bus.gray_valid = gray_valid;

    // Luma is the truncated high byte; the fraction is intentionally dropped.
    assign unused_frac = ^s1_sum[7:0];

    luma_mac #(.WR(WR), .WG(WG), .WB(WB)) u_mac (
        .r   (r_byte),
        .g   (g_byte),
        .b   (mac_b),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !gs_enable) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            r_byte     <= 8'd0;
            g_byte     <= 8'd0;
            b_byte     <= 8'd0;
            s1_v       <= 1'b0;
            s1_sum     <= 16'd0;
            gray_data  <= 8'd0;
            gray_valid <= 1'b0;
            pix_cnt    <= '0;
            gs_done    <= 1'b0;
        end else begin
            gs_done <= 1'b0;
            case (state)
                IDLE:    state <= ACTIVE;
                DONE:    state <= ACTIVE;
                ACTIVE: begin
                    if (last_accept) begin
                        state   <= DONE;
                        gs_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE) begin
                // Every valid byte is taken; the overflow slot absorbs the one
                // that can arrive after pause rises.
                case (cnt)
                    2'd0: if (bus.rwm_valid) begin
                        r_byte <= bus.rwm_data;
                        cnt    <= 2'd1;
                    end
                    2'd1: if (bus.rwm_valid) begin
                        g_byte <= bus.rwm_data;
                        cnt    <= 2'd2;
                    end
                    2'd2: if (bus.rwm_valid) begin
                        if (s1_free) begin
                            cnt <= 2'd0;
                        end else begin
                            b_byte <= bus.rwm_data;
                            cnt    <= 2'd3;
                        end
                    end
                    default: if (s1_free) begin
                        if (bus.rwm_valid) begin
                            r_byte <= bus.rwm_data;
                            cnt    <= 2'd1;
                        end else begin
                            cnt <= 2'd0;
                        end
                    end
                endcase

                if (load_s1) begin
                    s1_sum <= mac_sum;
                    s1_v   <= 1'b1;
                end else if (s1_adv) begin
                    s1_v <= 1'b0;
                end

                if (s1_adv) begin
                    gray_data  <= s1_sum[15:8];
                    gray_valid <= 1'b1;
                end else if (accept) begin
                    gray_valid <= 1'b0;
                end

                if (accept) begin
                    pix_cnt <= last_accept ? '0 : pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_grayscaler.sv
// Scoreboard bench for rgb_grayscaler: a byte-level luma model feeds an
// expected-pixel queue that an independent monitor drains on each handshake.
module tb_rgb_grayscaler;

    localparam int TB_N  = 2;
    localparam int TB_M  = 2;
    localparam int TB_WR = 77;
    localparam int TB_WG = 150;
    localparam int TB_WB = 29;
    localparam int FRAME = TB_N * TB_M;

    logic clk = 1'b0;
    logic rst_n;
    logic gs_enable;
    logic gs_done;

    rgb_grayscaler_if bus ();

    rgb_grayscaler #(
        .N(TB_N), .M(TB_M), .WR(TB_WR), .WG(TB_WG), .WB(TB_WB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gs_enable (gs_enable),
        .bus       (bus),
        .gs_done   (gs_done)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int miscompares = 0;

    int byte_q[$];
    int exp_q[$];
    int acc_count    = 0;
    int acc_total    = 0;
    int done_count   = 0;
    int bytes_sent   = 0;
    int last_out     = -1;
    bit done_pending = 0;
    bit pause_seen   = 0;
    bit hold_active  = 0;
    int held_data    = 0;
    bit stall        = 0;
    int ready_mode   = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int ref_luma(input int r, input int g, input int b);
        return (TB_WR * r + TB_WG * g + TB_WB * b) / 256;
    endfunction

    task automatic model_byte(input int b);
        byte_q.push_back(b);
        if (byte_q.size() == 3) begin
            exp_q.push_back(ref_luma(byte_q[0], byte_q[1], byte_q[2]));
            byte_q.delete();
        end
    endtask

    task automatic flush_model();
        byte_q.delete();
        exp_q.delete();
        acc_count    = 0;
        done_pending = 0;
        hold_active  = 0;
        stall        = 0;
    endtask

    // Behaves like the pixel buffer: a byte shown while pause is high still
    // counts, but no further byte is shown until pause drops.
    task automatic apply_stimulus(input logic [7:0] b, input bit capture);
        int guard;
        guard = 0;
        while (stall && guard < 1000) begin
            bus.rwm_valid = 1'b0;
            @(negedge clk);
            stall = bus.pause;
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) check_output("pause_timeout", guard, 0);
        bus.rwm_data  = b;
        bus.rwm_valid = 1'b1;
        bytes_sent++;
        if (capture) model_byte(int'(b));
        @(negedge clk);
        stall = bus.pause;
        @(posedge clk);
        #1;
        bus.rwm_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        flush_model();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_gray_valid", int'(bus.gray_valid), 0);
        check_output("reset_gray_data", int'(bus.gray_data), 0);
        check_output("reset_gs_done", int'(gs_done), 0);
        check_output("reset_pause", int'(bus.pause), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0) && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 500) check_output("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.gray_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.gray_ready = 1'b1;
                1:       bus.gray_ready = 1'b0;
                default: bus.gray_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted pixel and tracks framing.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("gs_done", int'(gs_done), int'(done_pending));
            if (gs_done) done_count++;
            done_pending = 0;
            if (bus.pause) pause_seen = 1;
            if (hold_active) begin
                check_output("hold_valid", int'(bus.gray_valid), 1);
                if (bus.gray_valid) check_output("hold_data", int'(bus.gray_data), held_data);
                hold_active = 0;
            end
            if (bus.gray_valid && bus.gray_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_pixel", int'(bus.gray_data), -1);
                end else begin
                    check_output("gray_data", int'(bus.gray_data), exp_q.pop_front());
                end
                last_out = int'(bus.gray_data);
                acc_total++;
                acc_count++;
                if (acc_count == FRAME) begin
                    acc_count    = 0;
                    done_pending = 1;
                end
            end else if (bus.gray_valid) begin
                hold_active = 1;
                held_data   = int'(bus.gray_data);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t2[12];
        int d0, a0;
        rst_n         = 1'b0;
        gs_enable     = 1'b1;
        bus.rwm_valid = 1'b0;
        bus.rwm_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single pixel latency");
        do_reset();
        pause_seen = 0;
        apply_stimulus(8'd100, 1);
        apply_stimulus(8'd50, 1);
        apply_stimulus(8'd200, 1);
        @(negedge clk);
        check_output("latency_early", int'(bus.gray_valid), 0);
        @(negedge clk);
        check_output("latency_valid", int'(bus.gray_valid), 1);
        check_output("latency_data", int'(bus.gray_data), 82);
        drain();
        check_output("no_pause", int'(pause_seen), 0);

        $display("[TB] corner triples, one frame");
        do_reset();
        t2 = '{255, 255, 255, 0, 0, 0, 255, 0, 0, 0, 255, 0};
        d0 = done_count;
        foreach (t2[i]) apply_stimulus(8'(t2[i]), 1);
        drain();
        check_output("frame_last_luma", last_out, 149);
        check_output("frame_done_count", done_count - d0, 1);

        $display("[TB] back-pressure");
        do_reset();
        d0 = done_count;
        a0 = acc_total;
        pause_seen = 0;
        bytes_sent = 0;
        ready_mode = 1;
        fork
            begin
                for (int i = 0; i < 12; i++) apply_stimulus(8'($urandom_range(0, 255)), 1);
            end
            begin
                repeat (20) @(posedge clk);
                #2;
                check_output("stall_bytes", bytes_sent, 9);
                check_output("stall_pause", int'(pause_seen), 1);
                ready_mode = 0;
            end
        join
        drain();
        check_output("bp_outputs", acc_total - a0, 4);
        check_output("bp_done_count", done_count - d0, 1);

        $display("[TB] mid-frame reset");
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(8'($urandom_range(0, 255)), 1);
        do_reset();
        d0 = done_count;
        a0 = acc_total;
        for (int i = 0; i < 12; i++) apply_stimulus(8'($urandom_range(0, 255)), 1);
        drain();
        check_output("rst_outputs", acc_total - a0, 4);
        check_output("rst_done_count", done_count - d0, 1);

        $display("[TB] random frames, random ready");
        do_reset();
        d0 = done_count;
        ready_mode = 2;
        for (int i = 0; i < 3 * FRAME * 3; i++) begin
            apply_stimulus(8'($urandom_range(0, 255)), 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        ready_mode = 0;
        drain();
        check_output("rand_done_count", done_count - d0, 3);

        $display("[TB] disabled input");
        a0 = acc_total;
        pause_seen = 0;
        gs_enable = 1'b0;
        for (int i = 0; i < 6; i++) apply_stimulus(8'($urandom_range(0, 255)), 0);
        repeat (2) @(posedge clk);
        #1;
        check_output("idle_outputs", acc_total - a0, 0);
        check_output("idle_pause", int'(pause_seen), 0);
        flush_model();
        gs_enable = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(8'd0, 1);
        apply_stimulus(8'd0, 1);
        apply_stimulus(8'd255, 1);
        drain();
        check_output("blue_luma", last_out, 28);
        check_output("blue_outputs", acc_total - a0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
